// File: rtl/a429_tx_sched.sv
// a429_tx_sched
// Round-robin scheduler that lets NSRC ARINC429 word sources share one
// transmitter. To the transmitter the block looks like a one-word FIFO
// (tf_rd / tf_do / tf_et). Source 0 can be given strict priority.
//
// Ports
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   src_vld   per-source word valid, held until the matching src_rdy pulse
//   src_dat   per-source 32-bit word, source k in bits [32k+31:32k]
//   src_rdy   registered one-cycle accept pulse (one-hot or zero)
//   src_en    per-source enable mask
//   pri_en    source 0 wins over round-robin when set
//   flush     drop the held/loading word and return to arbitration
//   tf_rd     transmitter read strobe
//   tf_do     held word
//   tf_et     1 = no word held
//   tf_src    source index of the held word
//   word_cnt  words consumed through tf_rd, wraps at 16 bits
module a429_tx_sched #(
  parameter int NSRC = 4,
  parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NSRC-1:0]    src_vld,
  input  logic [32*NSRC-1:0] src_dat,
  output logic [NSRC-1:0]    src_rdy,
  input  logic [NSRC-1:0]    src_en,
  input  logic               pri_en,
  input  logic               flush,
  input  logic               tf_rd,
  output logic [31:0]        tf_do,
  output logic               tf_et,
  output logic [SW-1:0]      tf_src,
  output logic [15:0]        word_cnt
);

  // One extra bit so last + offset (at most 2*NSRC-1) never overflows
  // before it is folded back into range.
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_ARB, S_LOAD, S_FULL} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   last;
  logic [SW-1:0]   grant;
  logic            grant_pri;
  logic [NSRC-1:0] elig;
  logic            any_elig;
  logic            use_pri;
  logic            rr_found;
  logic [SW-1:0]   rr_idx;
  logic [SW-1:0]   next_grant;
  logic [CW-1:0]   cand;
  logic [31:0]     words [NSRC];

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      words[k] = src_dat[32*k +: 32];
    end
  end

  // Round-robin search starts just after the last non-priority grant, so
  // the most recently served source is considered last.
  always_comb begin
    elig     = src_vld & src_en;
    any_elig = |elig;
    use_pri  = pri_en & elig[0];
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= NSRC; i++) begin
      cand = {1'b0, last} + CW'(i);
      if (cand >= CW'(NSRC)) begin
        cand = cand - CW'(NSRC);
      end
      if (!rr_found && elig[cand[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SW-1:0];
      end
    end
    next_grant = use_pri ? '0 : rr_idx;
  end

  // flush overrides everything and sends the block back to arbitration;
  // a flush in S_ARB also suppresses the grant for that cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_ARB: begin
        if (!flush && any_elig) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        state_n = flush ? S_ARB : S_FULL;
      end
      S_FULL: begin
        if (flush || tf_rd) begin
          state_n = S_ARB;
        end
      end
      default: state_n = S_ARB;
    endcase
  end

  // src_rdy is raised on the edge that enters S_LOAD so it is high for the
  // whole load cycle; the word is captured on the edge that leaves it.
  // The grant is committed in S_LOAD, so the source is counted as served
  // (pointer moves) even if a flush drops the word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= S_ARB;
      last      <= SW'(NSRC - 1);
      grant     <= '0;
      grant_pri <= 1'b0;
      src_rdy   <= '0;
      tf_do     <= '0;
      tf_src    <= '0;
      tf_et     <= 1'b1;
      word_cnt  <= '0;
    end else begin
      state   <= state_n;
      src_rdy <= '0;
      case (state)
        S_ARB: begin
          if (!flush && any_elig) begin
            grant     <= next_grant;
            grant_pri <= use_pri;
            src_rdy   <= {{(NSRC-1){1'b0}}, 1'b1} << next_grant;
          end
        end
        S_LOAD: begin
          if (!grant_pri) begin
            last <= grant;
          end
          if (!flush) begin
            tf_do  <= words[grant];
            tf_src <= grant;
            tf_et  <= 1'b0;
          end
        end
        S_FULL: begin
          if (flush) begin
            tf_et <= 1'b1;
          end else if (tf_rd) begin
            tf_et    <= 1'b1;
            word_cnt <= word_cnt + 16'd1;
          end
        end
        default: begin
          tf_et <= 1'b1;
        end
      endcase
    end
  end

endmodule
